mem_rmw_ctrl: RTL and testbench

Sequencing controller between the mem stage and the single-port data RAM. It accepts one load/store request at a time and drives the RAM port. Sub-word stores (SB/SH) run as a read-modify-write over multiple cycles. Loads are byte/half selected and sign/zero extended. The controller asserts a stall to the pipeline until the access completes.

---
 rtl/mem_rmw_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_rmw_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rmw_ctrl.sv
// ============================================================================
// mem_rmw_ctrl : load/store sequencer for a single-port word RAM, doing
//                read-modify-write for sub-word stores and load extension.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mem_rmw_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  done_o,
  output logic                  stall_o,
  output logic                  misalign_o
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
  localparam logic [DATA_WIDTH-1:0] HALF_MASK = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RMW_WAIT = 3'd2,
    WR       = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [15:0] sdata_q;

  logic [1:0]  off;
  logic        misalign_in;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign off       = mem_addr_i[1:0];
  assign word_addr = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign stall_o   = req_i & ~done_o;

  always_comb begin
    misalign_in = 1'b0;
    case (mem_op_i)
      OP_LH, OP_LHU, OP_SH: misalign_in = off[0];
      OP_LW, OP_SW:         misalign_in = (off != 2'b00);
      default:              misalign_in = 1'b0;
    endcase
  end

  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [3:0]            op,
    input logic [1:0]            lane,
    input logic [DATA_WIDTH-1:0] word
  );
    logic [DATA_WIDTH-1:0] shifted;
    logic [7:0]            b;
    logic [15:0]           h;
    shifted = word >> {lane, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    case (op)
      OP_LB:   load_extend = {{(DATA_WIDTH-8){b[7]}}, b};
      OP_LBU:  load_extend = {{(DATA_WIDTH-8){1'b0}}, b};
      OP_LH:   load_extend = {{(DATA_WIDTH-16){h[15]}}, h};
      OP_LHU:  load_extend = {{(DATA_WIDTH-16){1'b0}}, h};
      default: load_extend = word;
    endcase
  endfunction

  // Replicate the store data across all lanes and let the mask pick the target lane.
  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [3:0]            op,
    input logic [1:0]            lane,
    input logic [DATA_WIDTH-1:0] word,
    input logic [15:0]           sdata
  );
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] ins;
    if (op == OP_SB) begin
      mask = BYTE_MASK << {lane, 3'b000};
      ins  = {(DATA_WIDTH/8){sdata[7:0]}};
    end else begin
      mask = HALF_MASK << {lane[1], 4'b0000};
      ins  = {(DATA_WIDTH/16){sdata}};
    end
    store_merge = (word & ~mask) | (ins & mask);
  endfunction

  // done_o is high for the single cycle spent in DONE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      op_q        <= OP_NONE;
      off_q       <= 2'b00;
      sdata_q     <= 16'h0000;
      ram_ce_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      rdata_o     <= '0;
      done_o      <= 1'b0;
      misalign_o  <= 1'b0;
    end else begin
      ram_ce_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            op_q    <= mem_op_i;
            off_q   <= off;
            sdata_q <= mem_data_i[15:0];
            if (misalign_in) begin
              misalign_o <= 1'b1;
              done_o     <= 1'b1;
              rdata_o    <= '0;
              state      <= DONE;
            end else begin
              case (mem_op_i)
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                  ram_ce_o   <= 1'b1;
                  ram_addr_o <= word_addr;
                  state      <= RD_WAIT;
                end
                OP_SW: begin
                  ram_ce_o    <= 1'b1;
                  ram_we_o    <= 1'b1;
                  ram_addr_o  <= word_addr;
                  ram_wdata_o <= mem_data_i;
                  done_o      <= 1'b1;
                  state       <= DONE;
                end
                OP_SB, OP_SH: begin
                  ram_ce_o   <= 1'b1;
                  ram_addr_o <= word_addr;
                  state      <= RMW_WAIT;
                end
                default: begin
                  done_o <= 1'b1;
                  state  <= DONE;
                end
              endcase
            end
          end
        end
        RD_WAIT: begin
          rdata_o <= load_extend(op_q, off_q, ram_rdata_i);
          done_o  <= 1'b1;
          state   <= DONE;
        end
        RMW_WAIT: begin
          ram_ce_o    <= 1'b1;
          ram_we_o    <= 1'b1;
          ram_wdata_o <= store_merge(op_q, off_q, ram_rdata_i, sdata_q);
          state       <= WR;
        end
        WR: begin
          done_o <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_rmw_ctrl.sv
// ============================================================================
// tb_mem_rmw_ctrl : directed self-checking bench for mem_rmw_ctrl.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_mem_rmw_ctrl;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] ram_rdata_i;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        stall_o;
  logic        misalign_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;

  always #5 clk_i = ~clk_i;

  mem_rmw_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .req_i      (req_i),
    .mem_op_i   (mem_op_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .ram_rdata_i(ram_rdata_i),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .rdata_o    (rdata_o),
    .done_o     (done_o),
    .stall_o    (stall_o),
    .misalign_o (misalign_o)
  );

  // RAM model: read data presents the addressed word; writes land on the clock edge.
  assign ram_rdata_i = mem[ram_addr_o[9:2]];
  always @(posedge clk_i) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (ram_ce_o && ram_we_o) mem[ram_addr_o[9:2]] <= ram_wdata_o;
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    pre_en = 1'b1;
    pre_a  = addr[9:2];
    pre_d  = data;
    tick();
    pre_en = 1'b0;
  endtask

  // Issue one request held until done_o; report latency and RAM activity.
  task automatic xact(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                      output int lat, output int n_ce, output int n_we,
                      output logic [31:0] wd, output logic mis, output logic [31:0] rd);
    logic stall_bad;
    mem_op_i   = op;
    mem_addr_i = addr;
    mem_data_i = data;
    req_i      = 1'b1;
    lat = 0; n_ce = 0; n_we = 0; wd = 32'h0; stall_bad = 1'b0;
    while (lat < 10) begin
      tick();
      lat++;
      if (ram_ce_o) n_ce++;
      if (ram_we_o) begin n_we++; wd = ram_wdata_o; end
      if (done_o) break;
      if (stall_o !== 1'b1) stall_bad = 1'b1;
    end
    mis = misalign_o;
    rd  = rdata_o;
    check("timeout", {31'd0, done_o}, 32'd1);
    check("stall_pre_done", {31'd0, stall_bad}, 32'd0);
    check("stall_at_done", {31'd0, stall_o}, 32'd0);
    req_i    = 1'b0;
    mem_op_i = OP_NONE;
    tick();
    check("done_one_cycle", {31'd0, done_o}, 32'd0);
  endtask

  int          lat, n_ce, n_we;
  logic [31:0] wd, rd;
  logic        mis;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i    = 1'b0;
    req_i      = 1'b1;
    mem_op_i   = OP_LW;
    mem_addr_i = 32'h100;
    mem_data_i = 32'h0;
    pre_en     = 1'b0;
    pre_a      = 8'h0;
    pre_d      = 32'h0;

    poke(32'h100, 32'h8899AABB);
    tick();
    check("rst_ctrl", {28'd0, ram_ce_o, ram_we_o, done_o, misalign_o}, 32'h0);
    check("rst_addr", ram_addr_o, 32'h0);
    check("rst_wdata", ram_wdata_o, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);

    rst_n_i = 1'b1;
    tick();
    check("lw_cyc1_cewe", {30'd0, ram_ce_o, ram_we_o}, 32'h2);
    check("lw_cyc1_addr", ram_addr_o, 32'h100);
    check("lw_cyc1_stall", {31'd0, stall_o}, 32'd1);
    check("lw_cyc1_done", {31'd0, done_o}, 32'd0);
    tick();
    check("lw_cyc2_done", {31'd0, done_o}, 32'd1);
    check("lw_rdata", rdata_o, 32'h8899AABB);
    check("lw_cyc2_ce", {31'd0, ram_ce_o}, 32'd0);
    req_i    = 1'b0;
    mem_op_i = OP_NONE;
    tick();
    check("lw_done_pulse", {31'd0, done_o}, 32'd0);

    xact(OP_LB, 32'h103, 32'h0, lat, n_ce, n_we, wd, mis, rd);
    check("lb_103", rd, 32'hFFFFFF88);
    check("lb_lat", lat, 2);
    xact(OP_LBU, 32'h103, 32'h0, lat, n_ce, n_we, wd, mis, rd);
    check("lbu_103", rd, 32'h00000088);
    xact(OP_LH, 32'h102, 32'h0, lat, n_ce, n_we, wd, mis, rd);
    check("lh_102", rd, 32'hFFFF8899);
    xact(OP_LB, 32'h100, 32'h0, lat, n_ce, n_we, wd, mis, rd);
    check("lb_100", rd, 32'hFFFFFFBB);
    xact(OP_LBU, 32'h101, 32'h0, lat, n_ce, n_we, wd, mis, rd);
    check("lbu_101", rd, 32'h000000AA);
    xact(OP_LH, 32'h100, 32'h0, lat, n_ce, n_we, wd, mis, rd);
    check("lh_100", rd, 32'hFFFFAABB);
    xact(OP_LHU, 32'h102, 32'h0, lat, n_ce, n_we, wd, mis, rd);
    check("lhu_102", rd, 32'h00008899);
    check("lhu_ce_cnt", n_ce, 1);
    check("lhu_we_cnt", n_we, 0);

    poke(32'h100, 32'h11223344);
    xact(OP_SB, 32'h101, 32'hFFFFFFCD, lat, n_ce, n_we, wd, mis, rd);
    check("sb_wdata", wd, 32'h1122CD44);
    check("sb_lat", lat, 3);
    check("sb_ce_cnt", n_ce, 2);
    check("sb_we_cnt", n_we, 1);
    check("sb_mem", mem[8'h40], 32'h1122CD44);
    check("sb_rdata_hold", rd, 32'h00008899);

    poke(32'h100, 32'h11223344);
    xact(OP_SH, 32'h102, 32'h0000BEEF, lat, n_ce, n_we, wd, mis, rd);
    check("sh_wdata", wd, 32'hBEEF3344);
    check("sh_mem", mem[8'h40], 32'hBEEF3344);

    xact(OP_SW, 32'h200, 32'hDEADBEEF, lat, n_ce, n_we, wd, mis, rd);
    check("sw_lat", lat, 1);
    check("sw_we_cnt", n_we, 1);
    check("sw_wdata", wd, 32'hDEADBEEF);
    check("sw_mem", mem[8'h80], 32'hDEADBEEF);
    check("sw_rdata_hold", rd, 32'h00008899);

    xact(OP_LH, 32'h201, 32'h0, lat, n_ce, n_we, wd, mis, rd);
    check("lh_mis_flag", {31'd0, mis}, 32'd1);
    check("lh_mis_ce", n_ce, 0);
    check("lh_mis_lat", lat, 1);
    check("lh_mis_rdata", rd, 32'h0);
    xact(OP_SW, 32'h202, 32'h12345678, lat, n_ce, n_we, wd, mis, rd);
    check("sw_mis_flag", {31'd0, mis}, 32'd1);
    check("sw_mis_ce", n_ce, 0);
    check("sw_mis_mem", mem[8'h80], 32'hDEADBEEF);

    xact(OP_NONE, 32'h300, 32'h0, lat, n_ce, n_we, wd, mis, rd);
    check("none_lat", lat, 1);
    check("none_ce", n_ce, 0);
    check("none_mis", {31'd0, mis}, 32'd0);

    // Reset during RMW_WAIT of an SB
    poke(32'h100, 32'h11223344);
    mem_op_i = OP_SB; mem_addr_i = 32'h101; mem_data_i = 32'h000000AB; req_i = 1'b1;
    tick();
    n_we = ram_we_o ? 1 : 0;
    #2 rst_n_i = 1'b0;
    req_i = 1'b0; mem_op_i = OP_NONE;
    #2 rst_n_i = 1'b1;
    check("rst_mid_ce", {30'd0, ram_ce_o, ram_we_o}, 32'h0);
    repeat (3) begin
      tick();
      if (ram_we_o) n_we++;
    end
    check("rst_mid_we", n_we, 0);
    check("rst_mid_mem", mem[8'h40], 32'h11223344);
    check("rst_mid_done", {31'd0, done_o}, 32'd0);
    xact(OP_NONE, 32'h0, 32'h0, lat, n_ce, n_we, wd, mis, rd);
    check("rst_mid_idle_lat", lat, 1);

    // Inputs changing mid-load are ignored
    mem_op_i = OP_LW; mem_addr_i = 32'h100; mem_data_i = 32'h0; req_i = 1'b1;
    tick();
    mem_op_i = OP_SW; mem_addr_i = 32'h200; mem_data_i = 32'h0;
    tick();
    check("chg_done", {31'd0, done_o}, 32'd1);
    check("chg_addr", ram_addr_o, 32'h100);
    check("chg_rdata", rdata_o, 32'h11223344);
    check("chg_mem", mem[8'h80], 32'hDEADBEEF);
    req_i = 1'b0; mem_op_i = OP_NONE;
    tick();

    // Flush: req_i drops after acceptance, SB still completes
    mem_op_i = OP_SB; mem_addr_i = 32'h100; mem_data_i = 32'h00000077; req_i = 1'b1;
    tick();
    req_i = 1'b0; mem_op_i = OP_NONE;
    lat = 1;
    while (lat < 10 && !done_o) begin
      tick();
      lat++;
    end
    check("flush_done_lat", lat, 3);
    check("flush_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("flush_mem", mem[8'h40], 32'h11223377);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
